// File: rtl/maze_mem_pkg.sv
// Shared constants for the maze row memory and its controller.
// The memory model and controller both size themselves from these.
package maze_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 6;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_DEPTH  = 64;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/maze_mem_ctrl_if.sv
// Requester side of the maze memory controller: game port (p0, read/write)
// and display scanner port (p1, read only).
interface maze_mem_ctrl_if
    import maze_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic [ADDR_W-1:0] p1_addr;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_addr,
        input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_addr,
        output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
    );

endinterface

// File: rtl/maze_mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Inputs are already masked for eligibility;
// the pointer names the port favoured on a tie and moves only on a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
        // The port just served yields the next tie to the other one.
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/maze_mem_ctrl.sv
// Maze row memory sequencer: clears every row after reset, then serves the
// game port and the display scanner one registered access per cycle.
module maze_mem_ctrl
    import maze_mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = MEM_DATA_W,
    parameter int unsigned       ADDR_W   = MEM_ADDR_W,
    parameter int unsigned       DEPTH    = MEM_DEPTH,
    parameter logic [DATA_W-1:0] INIT_ROW = '0
) (
    input  logic               clk,
    input  logic               rst,
    maze_mem_ctrl_if.slave     bus_if,
    output logic [ADDR_W-1:0]  mem_address_o,
    output logic               mem_command_o,
    inout  wire  [DATA_W-1:0]  mem_data_io,
    output logic               init_done_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                init_done_q, init_done_d;

    logic [1:0]          elig;
    logic [1:0]          win;
    logic                rd_access;

    // A port granted this cycle sits out the next pick so a held request
    // is not served twice.
    assign elig = {bus_if.p1_req & ~gnt_q[1], bus_if.p0_req & ~gnt_q[0]}
                & {2{state_q == ST_RUN}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (elig),
        .gnt_o (win)
    );

    assign rd_access = (cmd_q == CMD_READ);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = CMD_READ;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt_d       = 2'b00;
        init_done_d = init_done_q;
        rvalid_d    = gnt_q & {2{rd_access}};
        rdata0_d    = (gnt_q[0] && rd_access) ? mem_data_io : rdata0_q;
        rdata1_d    = (gnt_q[1] && rd_access) ? mem_data_io : rdata1_q;

        unique case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_W'(DEPTH)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cmd_d   = CMD_WRITE;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = INIT_ROW;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (win[0]) begin
                    gnt_d   = 2'b01;
                    addr_d  = bus_if.p0_addr;
                    cmd_d   = bus_if.p0_we ? CMD_WRITE : CMD_READ;
                    wdata_d = bus_if.p0_wdata;
                end else if (win[1]) begin
                    gnt_d   = 2'b10;
                    addr_d  = bus_if.p1_addr;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            cmd_q       <= CMD_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            init_done_q <= init_done_d;
        end
    end

    // The memory writes on any edge with a write command, so the bus is
    // only ever driven together with it.
    assign mem_data_io   = (cmd_q == CMD_WRITE) ? wdata_q : {DATA_W{1'bz}};
    assign mem_address_o = addr_q;
    assign mem_command_o = cmd_q;
    assign init_done_o   = init_done_q;

    assign bus_if.p0_gnt    = gnt_q[0];
    assign bus_if.p0_rvalid = rvalid_q[0];
    assign bus_if.p0_rdata  = rdata0_q;
    assign bus_if.p1_gnt    = gnt_q[1];
    assign bus_if.p1_rvalid = rvalid_q[1];
    assign bus_if.p1_rdata  = rdata1_q;

endmodule

// File: doc/maze_mem_ctrl.md
Name: maze_mem_ctrl

Overview:
- Sequencer and arbiter in front of the single-port maze row memory (64 rows, 64 bits, 6-bit address; command 1 = read, command 0 = write).
- After reset, sweeps every row to a known pattern.
- Then shares the memory between two requesters, one access per cycle:
  - port 0: game logic, read and write.
  - port 1: display scanner, read only.
- Owns the memory's command, address and bidirectional data lines.

Parameters:
- DATA_W, 64: row width in bits (memory data width).
- ADDR_W, 6: row address width.
- DEPTH, 64: number of rows swept during clear; must equal 2**ADDR_W.
- INIT_ROW, 64'h0: pattern written to every row during clear.

Ports:
- clk  in  1  system clock, 50 MHz; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request; held until p0_gnt.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 row address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 access occurs this cycle.
- p0_rvalid  out  1  p0_rdata valid; 1-cycle pulse.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req  in  1  port 1 read request; held until p1_gnt.
- p1_addr  in  ADDR_W  port 1 row address.
- p1_gnt  out  1  port 1 access occurs this cycle.
- p1_rvalid  out  1  p1_rdata valid; 1-cycle pulse.
- p1_rdata  out  DATA_W  port 1 read data.
- mem_address  out  ADDR_W  to memory address.
- mem_command  out  1  to memory command.
- mem_data  inout  DATA_W  to memory data bus.
- init_done  out  1  clear sweep finished; stays high until next reset.

Behaviour:
- All outputs are registered. Cycle 0 is the first cycle with rst low.
- Reset values:
  - mem_command = 1 (read); mem_address = 0; mem_data tri-stated.
  - gnt, rvalid, init_done = 0; rdata = 0.
  - State = CLEAR with clear counter = 0; round-robin pointer favours p0.
- Memory hazard: the memory writes on every edge where command = 0. mem_command must therefore be 0 only in cycles that perform an intended write; it is 1 in every other cycle, including idle and reset. mem_data is driven only when mem_command = 0.
- State machine:
  - CLEAR:
    - Write INIT_ROW to address cnt each cycle; rows 0..DEPTH-1 are written in cycles 1..DEPTH.
    - After the write to DEPTH-1, go to RUN; init_done is high from cycle DEPTH+1.
    - Requests are ignored in CLEAR, with no grants.
  - RUN:
    - At each edge, the arbiter picks among eligible requests.
    - The winner's address, write flag and write data are registered.
    - The following cycle is the access cycle: gnt is high for that port, with mem_address and mem_command set from the registered request.
- Eligibility:
  - A port whose gnt is high in the current cycle is ineligible at that edge, so a held request is not served twice.
  - A single port alone therefore gets at most every other cycle; alternating ports can be granted back-to-back.
- Arbitration:
  - When both ports are eligible, round-robin: the port not granted most recently wins.
  - The pointer updates only on a grant.
- Read access:
  - mem_command = 1; memory data is captured at the end of the access cycle.
  - rdata is updated and rvalid pulses high in the next cycle; rdata holds until the next read for that port.
- Write access:
  - mem_command = 0 and mem_data = registered wdata for exactly the access cycle.
  - No rvalid is produced.
- Port 1 is read only; it never causes mem_command = 0.
- Latency: request sampled at the edge ending cycle T, gnt in cycle T+1, rvalid and rdata in cycle T+2.
- Read-after-write to the same row on consecutive grants returns the new data.
- Reset asserted mid-operation:
  - Any in-flight access is abandoned, including a pending rvalid.
  - The bus is released and the block re-enters CLEAR from row 0.

Decomposition:
- Shared package/header maze_mem_pkg holds:
  - MEM_ADDR_W, MEM_DATA_W, MEM_DEPTH.
  - CMD_READ = 1, CMD_WRITE = 0.
  - State encoding CLEAR/RUN.
  - The memory module uses the same width constants.
- Sub-module rr_arb2: two-way round-robin arbiter with eligibility masks, a grant one-hot output and an internal pointer.

Test Plan:
- Reset release:
  - Probe mem_command and mem_address: command 0 exactly in cycles 1..64, addresses 0..63 in order.
  - init_done rises in cycle 65.
  - A read of row 17 by p0 after clear returns 64'h0.
- p0 writes 64'hDEAD_BEEF_0000_0011 to row 5, then p0 reads row 5:
  - p0_gnt for the write, one access cycle with command 0.
  - Read rvalid two cycles after its sample edge with the written value.
- Both ports request from the same cycle, held continuously:
  - Grants alternate p0, p1, p0, p1 …, with no idle cycles.
  - No port is granted twice from one held request.
- p1 alone holds a request:
  - p1_gnt high every other cycle.
  - mem_command never 0.
  - mem_data never driven by the block.
- rst asserted in the write access cycle of a p0 write to row 9:
  - Bus released and command 1 during reset.
  - Clear restarts at row 0; row 9 later reads INIT_ROW.
- Idle for 100 cycles after init:
  - mem_command stays 1, mem_data stays tri-stated.
  - All rows are unchanged on readback.
